urna_controle: RTL and testbench
================================

// Module: urna_controle
// PURPOSE
//  Voting-session controller sequencing the existing combinational conta_votos counter.
//  Opens a session on INICIO and collects one yes/no vote per voter during a bounded window.
//  Then presents the captured 3-bit vote vector to conta_votos and registers its 4-bit result.
//  Sits between the voter interface (buttons/strobes) and result display logic.
// PARAMETERS
//  N_VOT   3    number of voters; fixed at 3 to match conta_votos V width (not overridable in practice)
//  JANELA  16   session window length in clk cycles; legal range JANELA >= 2
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      reset, asynchronous, active-high
//  INICIO          in   1      start-session request, sampled only in OCIOSO
//  VOTO_VALIDO     in   N_VOT  per-voter vote strobe, 1 cycle per vote
//  VOTO_SIM        in   N_VOT  per-voter vote value (1=yes), qualified by VOTO_VALIDO[i]
//  OCUPADO         out  1      high in any state other than OCIOSO
//  JA_VOTOU        out  N_VOT  per-voter "vote recorded this session" flags
//  V_APURADO       out  N_VOT  captured vote vector fed to conta_votos (abstain = 0)
//  R               out  4      registered conta_votos result of the last completed session
//  PRONTO          out  1      one-cycle pulse: R/V_APURADO valid for a new session
//  ERRO_DUPLO      out  1      sticky per session: some voter strobed twice
//  TEMPO_ESGOTADO  out  1      sticky per session: session closed by timeout, not all votes in
// BEHAVIOUR
//  Reset (async, any time): state=OCIOSO; all outputs and the window counter = 0; a session in progress is discarded.
//  FSM states OCIOSO -> COLETA -> APURA -> PUBLICA -> OCIOSO.
//  OCIOSO: INICIO=1 -> COLETA; same edge clears JA_VOTOU, V_APURADO, ERRO_DUPLO, TEMPO_ESGOTADO, counter=0.
//   R is held from the previous session until the next PUBLICA.
//  COLETA, per voter i each cycle:
//   VOTO_VALIDO[i] & !JA_VOTOU[i] -> V_APURADO[i]<=VOTO_SIM[i], JA_VOTOU[i]<=1.
//   VOTO_VALIDO[i] & JA_VOTOU[i] -> vote unchanged (first vote wins), ERRO_DUPLO<=1.
//   Simultaneous strobes from different voters are all accepted in the same cycle (no arbitration loss).
//   Counter increments every COLETA cycle, width $clog2(JANELA), never wraps.
//   Exit to APURA when next-JA_VOTOU == all ones (includes votes accepted this cycle),
//    or when counter == JANELA-1.
//   Timeout exit with next-JA_VOTOU != all ones -> TEMPO_ESGOTADO<=1; missing voters stay 0.
//   If the last vote arrives on the timeout cycle, it is accepted and TEMPO_ESGOTADO stays 0.
//  APURA (1 cycle): V_APURADO stable into conta_votos; R <= conta_votos.R at end of cycle.
//  PUBLICA (1 cycle): PRONTO=1, then -> OCIOSO.
//  Latency: the cycle after all-voted/timeout is APURA, the next is PUBLICA (PRONTO high). Session is at most JANELA+2 cycles.
//  INICIO outside OCIOSO is ignored; VOTO_VALIDO outside COLETA is ignored (no flags change).
//  Votes are not accepted in the cycle that INICIO is sampled.
//  OCUPADO = (state != OCIOSO), decoded from the state register; no combinational input-to-output path.
// STRUCTURE
//  Package conta_votos_pkg: localparam N_VOT=3, R_W=4; typedef enum logic [1:0] estado_t {OCIOSO,COLETA,APURA,PUBLICA}.
//  One sub-module: conta_votos (existing, combinational), instantiated as u_cv with .V(V_APURADO).
//  The FSM, window counter and vote registers live in this module; no further hierarchy.
// TESTING
//  Golden model: the bench instantiates its own conta_votos and compares R against model(V_APURADO) at each PRONTO.
//  1 Reset mid-COLETA after voter 0 voted -> all outputs 0, OCUPADO=0; next INICIO starts a clean session.
//  2 INICIO, then VOTO_VALIDO=3'b111 with VOTO_SIM=3'b101 in one cycle -> APURA next, PRONTO 2 cycles after the vote.
//     Expect V_APURADO=3'b101, R=model(3'b101), ERRO_DUPLO=0.
//  3 Staggered votes: v0=1 @c1, v2=0 @c3, v1=1 @c5 -> V_APURADO=3'b011, PRONTO at c7.
//  4 Only voter 1 votes yes (JANELA=16) -> timeout after 16 COLETA cycles.
//     Expect V_APURADO=3'b010, TEMPO_ESGOTADO=1, R=model(3'b010).
//  5 Voter 2 votes 1 then 0 -> V_APURADO[2]=1, ERRO_DUPLO=1 through PRONTO; cleared by next INICIO.
//  6 INICIO and VOTO_VALIDO during COLETA/APURA/PUBLICA, and votes while OCIOSO -> no effect.
//     R holds the previous value across all of this; sweep all 8 V patterns for exhaustive R coverage.

Source files
------------

// File: rtl/conta_votos_pkg.sv
// Shared types and sizes for the voting-session controller and its vote counter.
package conta_votos_pkg;

    localparam int N_VOT = 3;
    localparam int R_W   = 4;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        COLETA  = 2'd1,
        APURA   = 2'd2,
        PUBLICA = 2'd3
    } estado_t;

endpackage

// File: rtl/conta_votos.sv
// Combinational vote tally: R[2:0] = number of yes votes, R[3] = approved (yes majority).
module conta_votos
    import conta_votos_pkg::*;
(
    input  logic [N_VOT-1:0] V,
    output logic [R_W-1:0]   R
);

    logic [2:0] w_qtd_sim;

    always_comb begin
        w_qtd_sim = 3'd0;
        for (int i = 0; i < N_VOT; i++) begin
            w_qtd_sim = w_qtd_sim + {2'b00, V[i]};
        end
    end

    assign R = {(w_qtd_sim >= 3'd2), w_qtd_sim};

endmodule

// File: rtl/urna_controle.sv
// Voting-session controller: collects one vote per voter inside a bounded window,
// then tallies the captured vector through conta_votos and publishes the registered result.
module urna_controle
    import conta_votos_pkg::*;
#(
    parameter int JANELA = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             INICIO,
    input  logic [N_VOT-1:0] VOTO_VALIDO,
    input  logic [N_VOT-1:0] VOTO_SIM,
    output logic             OCUPADO,
    output logic [N_VOT-1:0] JA_VOTOU,
    output logic [N_VOT-1:0] V_APURADO,
    output logic [R_W-1:0]   R,
    output logic             PRONTO,
    output logic             ERRO_DUPLO,
    output logic             TEMPO_ESGOTADO
);

    localparam int CNT_W = (JANELA > 2) ? $clog2(JANELA) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(JANELA - 1);

    estado_t          r_estado, w_estado_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [N_VOT-1:0] r_ja, w_ja_nxt;
    logic [N_VOT-1:0] r_v, w_v_nxt;
    logic [R_W-1:0]   r_r, w_r_nxt;
    logic             r_erro, w_erro_nxt;
    logic             r_tempo, w_tempo_nxt;
    logic [R_W-1:0]   w_r_cv;

    conta_votos u_cv (
        .V (r_v),
        .R (w_r_cv)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado <= OCIOSO;
            r_cnt    <= '0;
            r_ja     <= '0;
            r_v      <= '0;
            r_r      <= '0;
            r_erro   <= 1'b0;
            r_tempo  <= 1'b0;
        end else begin
            r_estado <= w_estado_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ja     <= w_ja_nxt;
            r_v      <= w_v_nxt;
            r_r      <= w_r_nxt;
            r_erro   <= w_erro_nxt;
            r_tempo  <= w_tempo_nxt;
        end
    end

    always_comb begin
        w_estado_nxt = r_estado;
        w_cnt_nxt    = r_cnt;
        w_ja_nxt     = r_ja;
        w_v_nxt      = r_v;
        w_r_nxt      = r_r;
        w_erro_nxt   = r_erro;
        w_tempo_nxt  = r_tempo;
        unique case (r_estado)
            OCIOSO: begin
                if (INICIO) begin
                    w_estado_nxt = COLETA;
                    w_cnt_nxt    = '0;
                    w_ja_nxt     = '0;
                    w_v_nxt      = '0;
                    w_erro_nxt   = 1'b0;
                    w_tempo_nxt  = 1'b0;
                end
            end
            COLETA: begin
                // First vote wins; a repeat strobe only raises the duplicate flag.
                for (int i = 0; i < N_VOT; i++) begin
                    if (VOTO_VALIDO[i]) begin
                        if (!r_ja[i]) begin
                            w_v_nxt[i]  = VOTO_SIM[i];
                            w_ja_nxt[i] = 1'b1;
                        end else begin
                            w_erro_nxt = 1'b1;
                        end
                    end
                end
                if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                if (&w_ja_nxt) begin
                    w_estado_nxt = APURA;
                end else if (r_cnt == CNT_MAX) begin
                    w_estado_nxt = APURA;
                    w_tempo_nxt  = 1'b1;
                end
            end
            APURA: begin
                w_r_nxt      = w_r_cv;
                w_estado_nxt = PUBLICA;
            end
            PUBLICA: begin
                w_estado_nxt = OCIOSO;
            end
            default: begin
                w_estado_nxt = OCIOSO;
            end
        endcase
    end

    assign OCUPADO        = (r_estado != OCIOSO);
    assign PRONTO         = (r_estado == PUBLICA);
    assign JA_VOTOU       = r_ja;
    assign V_APURADO      = r_v;
    assign R              = r_r;
    assign ERRO_DUPLO     = r_erro;
    assign TEMPO_ESGOTADO = r_tempo;

endmodule

// File: tb/tb_urna_controle.sv
// Directed bench for urna_controle: hand-computed expectations plus a reference tally at each publish.
module tb_urna_controle;
    import conta_votos_pkg::*;

    logic             clk;
    logic             rst;
    logic             INICIO;
    logic [N_VOT-1:0] VOTO_VALIDO;
    logic [N_VOT-1:0] VOTO_SIM;
    logic             OCUPADO;
    logic [N_VOT-1:0] JA_VOTOU;
    logic [N_VOT-1:0] V_APURADO;
    logic [R_W-1:0]   R;
    logic             PRONTO;
    logic             ERRO_DUPLO;
    logic             TEMPO_ESGOTADO;
    logic [R_W-1:0]   w_model_r;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected tally per vote vector: {approved, yes count}
    logic [R_W-1:0] tab_r [8];

    urna_controle #(.JANELA(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .INICIO         (INICIO),
        .VOTO_VALIDO    (VOTO_VALIDO),
        .VOTO_SIM       (VOTO_SIM),
        .OCUPADO        (OCUPADO),
        .JA_VOTOU       (JA_VOTOU),
        .V_APURADO      (V_APURADO),
        .R              (R),
        .PRONTO         (PRONTO),
        .ERRO_DUPLO     (ERRO_DUPLO),
        .TEMPO_ESGOTADO (TEMPO_ESGOTADO)
    );

    conta_votos u_model (
        .V (V_APURADO),
        .R (w_model_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ocup"},  8'(OCUPADO), 8'd0);
        chk({tag, "_ja"},    8'(JA_VOTOU), 8'd0);
        chk({tag, "_v"},     8'(V_APURADO), 8'd0);
        chk({tag, "_r"},     8'(R), 8'd0);
        chk({tag, "_pronto"}, 8'(PRONTO), 8'd0);
        chk({tag, "_erro"},  8'(ERRO_DUPLO), 8'd0);
        chk({tag, "_tempo"}, 8'(TEMPO_ESGOTADO), 8'd0);
    endtask

    task automatic vote(input logic [2:0] vv, input logic [2:0] vs);
        VOTO_VALIDO = vv;
        VOTO_SIM    = vs;
        tick();
        VOTO_VALIDO = '0;
        VOTO_SIM    = '0;
    endtask

    task automatic start();
        INICIO = 1'b1;
        tick();
        INICIO = 1'b0;
    endtask

    initial begin
        tab_r[0] = 4'd0;  tab_r[1] = 4'd1;  tab_r[2] = 4'd1;  tab_r[3] = 4'd10;
        tab_r[4] = 4'd1;  tab_r[5] = 4'd10; tab_r[6] = 4'd10; tab_r[7] = 4'd11;
        rst = 1'b1; INICIO = 1'b0; VOTO_VALIDO = '0; VOTO_SIM = '0;
        tick(); tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        // Reset in the middle of a session
        start();
        chk("t1_ocup", 8'(OCUPADO), 8'd1);
        vote(3'b001, 3'b001);
        chk("t1_ja", 8'(JA_VOTOU), 8'd1);
        chk("t1_v", 8'(V_APURADO), 8'd1);
        #2 rst = 1'b1;
        #1;
        chk_zero("t1_async");
        rst = 1'b0;
        tick();

        // All three vote in a single cycle
        start();
        chk("t2_ja0", 8'(JA_VOTOU), 8'd0);
        vote(3'b111, 3'b101);
        chk("t2_apura_ocup", 8'(OCUPADO), 8'd1);
        chk("t2_apura_pronto", 8'(PRONTO), 8'd0);
        chk("t2_ja", 8'(JA_VOTOU), 8'd7);
        tick();
        chk("t2_pronto", 8'(PRONTO), 8'd1);
        chk("t2_v", 8'(V_APURADO), 8'd5);
        chk("t2_r", 8'(R), 8'd10);
        chk("t2_model", 8'(R), 8'(w_model_r));
        chk("t2_erro", 8'(ERRO_DUPLO), 8'd0);
        chk("t2_tempo", 8'(TEMPO_ESGOTADO), 8'd0);
        tick();
        chk("t2_idle_pronto", 8'(PRONTO), 8'd0);
        chk("t2_idle_ocup", 8'(OCUPADO), 8'd0);
        chk("t2_r_hold", 8'(R), 8'd10);

        // Staggered votes
        start();
        vote(3'b001, 3'b001);
        tick();
        vote(3'b100, 3'b000);
        chk("t3_ja", 8'(JA_VOTOU), 8'd5);
        chk("t3_ocup", 8'(OCUPADO), 8'd1);
        tick();
        vote(3'b010, 3'b010);
        chk("t3_apura_pronto", 8'(PRONTO), 8'd0);
        tick();
        chk("t3_pronto", 8'(PRONTO), 8'd1);
        chk("t3_v", 8'(V_APURADO), 8'd3);
        chk("t3_r", 8'(R), 8'd10);
        chk("t3_model", 8'(R), 8'(w_model_r));
        tick();

        // Timeout with only voter 1 in
        start();
        vote(3'b010, 3'b010);
        repeat (14) tick();
        chk("t4_last_pronto", 8'(PRONTO), 8'd0);
        chk("t4_last_tempo", 8'(TEMPO_ESGOTADO), 8'd0);
        chk("t4_last_ocup", 8'(OCUPADO), 8'd1);
        tick();
        chk("t4_apura_tempo", 8'(TEMPO_ESGOTADO), 8'd1);
        chk("t4_apura_pronto", 8'(PRONTO), 8'd0);
        tick();
        chk("t4_pronto", 8'(PRONTO), 8'd1);
        chk("t4_v", 8'(V_APURADO), 8'd2);
        chk("t4_r", 8'(R), 8'd1);
        chk("t4_model", 8'(R), 8'(w_model_r));
        tick();

        // Final vote arrives on the timeout cycle
        start();
        vote(3'b011, 3'b011);
        repeat (14) tick();
        vote(3'b100, 3'b100);
        chk("t4b_ja", 8'(JA_VOTOU), 8'd7);
        chk("t4b_tempo", 8'(TEMPO_ESGOTADO), 8'd0);
        tick();
        chk("t4b_pronto", 8'(PRONTO), 8'd1);
        chk("t4b_r", 8'(R), 8'd11);
        tick();

        // Duplicate strobe from voter 2
        start();
        vote(3'b100, 3'b100);
        vote(3'b100, 3'b000);
        chk("t5_erro", 8'(ERRO_DUPLO), 8'd1);
        chk("t5_v2", 8'(V_APURADO), 8'd4);
        vote(3'b011, 3'b000);
        tick();
        chk("t5_pronto", 8'(PRONTO), 8'd1);
        chk("t5_erro_pub", 8'(ERRO_DUPLO), 8'd1);
        chk("t5_r", 8'(R), 8'd1);
        chk("t5_model", 8'(R), 8'(w_model_r));
        tick();
        start();
        chk("t5_erro_clr", 8'(ERRO_DUPLO), 8'd0);

        // Ignored INICIO and out-of-window strobes
        INICIO = 1'b1;
        tick();
        chk("t6_inicio_coleta", 8'(JA_VOTOU), 8'd0);
        VOTO_VALIDO = 3'b111; VOTO_SIM = 3'b000;
        tick();
        VOTO_SIM = 3'b111;
        chk("t6_apura_ocup", 8'(OCUPADO), 8'd1);
        tick();
        chk("t6_pub_v", 8'(V_APURADO), 8'd0);
        chk("t6_pub_r", 8'(R), 8'd0);
        chk("t6_pub_erro", 8'(ERRO_DUPLO), 8'd0);
        INICIO = 1'b0;
        tick();
        chk("t6_idle_v", 8'(V_APURADO), 8'd0);
        tick(); tick();
        chk("t6_idle_ja", 8'(JA_VOTOU), 8'd7);
        chk("t6_idle_v2", 8'(V_APURADO), 8'd0);
        chk("t6_idle_ocup", 8'(OCUPADO), 8'd0);
        chk("t6_idle_r", 8'(R), 8'd0);
        VOTO_VALIDO = '0; VOTO_SIM = '0;

        // Every vote vector through the tally
        for (int p = 0; p < 8; p++) begin
            start();
            vote(3'b111, 3'(p));
            tick();
            chk($sformatf("sweep%0d_pronto", p), 8'(PRONTO), 8'd1);
            chk($sformatf("sweep%0d_v", p), 8'(V_APURADO), 8'(p));
            chk($sformatf("sweep%0d_r", p), 8'(R), 8'(tab_r[p]));
            chk($sformatf("sweep%0d_model", p), 8'(R), 8'(w_model_r));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
